// File: rtl/rv32i_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// rv32i_fetch_unit_if
// Bundles every bus of the fetch stage apart from clk/reset: the imem
// request/response channel, the redirect from execute, the decode-side
// instruction channel and two debug taps on the slot queue.
//
// Handshake rule for every valid/ready pair in this interface: a transfer
// happens on a rising clk edge where valid and ready are both high. The
// producer holds its payload stable while valid is high and ready is low.
// valid never depends on ready. The imem response channel has no ready
// signal, so the fetch unit always takes a response.
//
// Modports
//   master : the fetch unit (issues imem requests, drives decode outputs)
//   slave  : the environment (instruction memory, execute, decode)
// Debug taps (driven by master)
//   dbg_slot_state : 2 bits per slot, slot i at [2*i +: 2]
//                    (0 empty, 1 pending, 2 filled)
//   dbg_occupancy  : number of allocated slots, 0..DEPTH
// ---------------------------------------------------------------------------
interface rv32i_fetch_unit_if #(
  parameter int unsigned DEPTH = 2
);
  logic                     imem_req_valid;
  logic                     imem_req_ready;
  logic [31:0]              imem_req_addr;
  logic                     imem_rsp_valid;
  logic [31:0]              imem_rsp_data;
  logic                     redirect_valid;
  logic [31:0]              redirect_pc;
  logic                     id_valid;
  logic                     id_ready;
  logic [31:0]              id_instr;
  logic [31:0]              id_pc;
  logic [31:0]              id_pc_plus4;
  logic [2*DEPTH-1:0]       dbg_slot_state;
  logic [$clog2(DEPTH):0]   dbg_occupancy;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output id_valid, id_instr, id_pc, id_pc_plus4,
    input  id_ready,
    output dbg_slot_state, dbg_occupancy
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  id_valid, id_instr, id_pc, id_pc_plus4,
    output id_ready,
    input  dbg_slot_state, dbg_occupancy
  );
endinterface

// File: rtl/rv32i_fetch_unit.sv
// ---------------------------------------------------------------------------
// rv32i_fetch_unit
// Instruction-fetch stage. Holds the PC, issues in-order word requests to
// instruction memory, parks each fetch in a slot of a small circular queue
// (EMPTY -> PENDING on request accept -> FILLED on response -> EMPTY on
// hand-off to decode) and presents the head slot to decode. A redirect from
// execute replaces the PC, empties the queue and arranges for every response
// still owed by memory for older requests to be thrown away.
//
// Parameters
//   RESET_PC : first PC fetched after reset
//   DEPTH    : slot count (power of two, >= 2); also the request limit
// Ports
//   clk, reset : single clock, synchronous active-high reset
//   bus        : rv32i_fetch_unit_if.master (imem, redirect, decode, debug)
// ---------------------------------------------------------------------------
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  rv32i_fetch_unit_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  // Responses owed for squashed requests; wide enough that repeated
  // redirects against a slow memory cannot wrap it.
  localparam int unsigned KW = 16;

  typedef enum logic [1:0] {
    SLOT_EMPTY   = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_FILLED  = 2'd2
  } slot_state_e;

  slot_state_e   slot_q [DEPTH];
  slot_state_e   slot_d [DEPTH];
  logic [31:0]   slot_pc_q [DEPTH];
  logic [31:0]   slot_instr_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [PW-1:0] fill_q;   // oldest PENDING slot (responses return in order)
  logic [CW-1:0] occ_q;
  logic [CW-1:0] occ_d;
  logic [KW-1:0] kill_q;
  logic [KW-1:0] kill_d;
  logic [31:0]   pc_q;
  logic [31:0]   pc_d;
  logic          boot_q;   // high for the first cycle out of reset

  logic          redir;
  logic          req_fire;
  logic          rsp_fill;
  logic          id_fire;
  logic          queue_empty;
  logic          head_filled;
  logic [CW-1:0] pend_cnt;

  assign redir       = bus.redirect_valid;
  assign queue_empty = (occ_q == '0);
  assign head_filled = (slot_q[head_q] == SLOT_FILLED);

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_q[i] == SLOT_PENDING) pend_cnt = pend_cnt + 1'b1;
    end
  end

  // Outputs are forced quiet while reset is high, so nothing leaks before
  // the first reset edge has initialised the state.
  assign bus.imem_req_valid = !reset && !boot_q && !redir && (occ_q < CW'(DEPTH));
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign bus.id_valid    = !reset && head_filled && !redir;
  assign id_fire         = bus.id_valid && bus.id_ready;
  assign bus.id_instr    = (reset || queue_empty) ? 32'd0 : slot_instr_q[head_q];
  assign bus.id_pc       = (reset || queue_empty) ? 32'd0 : slot_pc_q[head_q];
  assign bus.id_pc_plus4 = bus.id_pc + 32'd4;

  // A response only lands in a slot when nothing older is still owed.
  assign rsp_fill = bus.imem_rsp_valid && !redir && (kill_q == '0) &&
                    (slot_q[fill_q] == SLOT_PENDING);

  always_comb begin
    bus.dbg_slot_state = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.dbg_slot_state[2*i +: 2] = logic'(1'b0) ? 2'b00 : slot_q[i];
    end
  end
  assign bus.dbg_occupancy = occ_q;

  // Slot FSMs plus PC / occupancy / kill next-state.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) slot_d[i] = slot_q[i];
    occ_d  = occ_q;
    pc_d   = pc_q;
    kill_d = kill_q;
    if (redir) begin
      for (int i = 0; i < DEPTH; i++) slot_d[i] = SLOT_EMPTY;
      occ_d = '0;
      pc_d  = {bus.redirect_pc[31:2], 2'b00};
      // Everything still owed becomes a drop: the pending slots plus the old
      // count, less the response (if any) consumed in this very cycle.
      if (bus.imem_rsp_valid && ((kill_q != '0) || (pend_cnt != '0)))
        kill_d = kill_q + KW'(pend_cnt) - KW'(1);
      else
        kill_d = kill_q + KW'(pend_cnt);
    end else begin
      // Head, fill and tail point at slots in three different states, so
      // these updates never collide.
      if (id_fire)  slot_d[head_q] = SLOT_EMPTY;
      if (rsp_fill) slot_d[fill_q] = SLOT_FILLED;
      if (req_fire) begin
        slot_d[tail_q] = SLOT_PENDING;
        pc_d           = pc_q + 32'd4;
      end
      if (bus.imem_rsp_valid && (kill_q != '0)) kill_d = kill_q - 1'b1;
      case ({req_fire, id_fire})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      occ_q  <= '0;
      kill_q <= '0;
      boot_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i]       <= SLOT_EMPTY;
        slot_pc_q[i]    <= '0;
        slot_instr_q[i] <= '0;
      end
    end else begin
      boot_q <= 1'b0;
      pc_q   <= pc_d;
      occ_q  <= occ_d;
      kill_q <= kill_d;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
      if (redir) begin
        head_q <= '0;
        tail_q <= '0;
        fill_q <= '0;
      end else begin
        if (id_fire) head_q <= head_q + 1'b1;
        if (rsp_fill) begin
          slot_instr_q[fill_q] <= bus.imem_rsp_data;
          fill_q               <= fill_q + 1'b1;
        end
        if (req_fire) begin
          slot_pc_q[tail_q] <= pc_q;
          tail_q            <= tail_q + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_rv32i_fetch_unit
// Directed phases with randomized handshakes around rv32i_fetch_unit. The
// reference model tracks the fetch stream abstractly: the expected next
// request address, a queue of accepted-but-undelivered PCs, how many of those
// already have their data back, and an epoch number that marks responses for
// squashed requests. Instruction memory returns a fixed function of the
// address, in order, after a random latency.
// ---------------------------------------------------------------------------
module tb_rv32i_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mem_t;

  logic clk;
  logic reset;
  rv32i_fetch_unit_if #(.DEPTH(DEPTH)) m ();

  rv32i_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m)
  );

  // ---- clock / reset ------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- model state --------------------------------------------------------
  logic [31:0] exp_q[$];     // PCs accepted by imem, not yet handed to decode
  mem_t        mem_q[$];     // requests memory still owes a response for
  logic [31:0] exp_addr;
  int          filled;       // how many of exp_q already have data back
  int          epoch;
  bit          boot;
  int          cyc;
  int          checks;
  int          errors;
  int          req_rdy_pct, id_rdy_pct, rsp_pct, lat_max;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_A5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- driver: one clock cycle --------------------------------------------
  task automatic step(input bit do_rst, input bit do_redir, input logic [31:0] tgt);
    bit   rsp_now;
    mem_t e;
    bit   req_fire;
    bit   id_fire;
    @(negedge clk);
    reset            = do_rst;
    m.redirect_valid = do_redir && !do_rst;
    m.redirect_pc    = tgt;
    m.imem_req_ready = ($urandom_range(99) < req_rdy_pct);
    m.id_ready       = ($urandom_range(99) < id_rdy_pct);
    rsp_now = 1'b0;
    if (!do_rst && mem_q.size() > 0 && mem_q[0].due <= cyc)
      rsp_now = ($urandom_range(99) < rsp_pct);
    m.imem_rsp_valid = rsp_now;
    m.imem_rsp_data  = rsp_now ? mem_word(mem_q[0].addr) : $urandom;
    #1;

    // ---- scoreboard compare ----
    if (do_rst || boot) begin
      check("rst_req_valid", 32'(m.imem_req_valid), 32'd0);
      check("rst_id_valid",  32'(m.id_valid), 32'd0);
      check("rst_id_pc",     m.id_pc, 32'd0);
      check("rst_id_instr",  m.id_instr, 32'd0);
    end else begin
      check("req_valid", 32'(m.imem_req_valid),
            32'(!do_redir && (exp_q.size() < DEPTH)));
      if (m.imem_req_valid) check("req_addr", m.imem_req_addr, exp_addr);
      check("id_valid", 32'(m.id_valid), 32'(!do_redir && (filled > 0)));
      if (m.id_valid && exp_q.size() > 0) begin
        check("id_pc",       m.id_pc, exp_q[0]);
        check("id_instr",    m.id_instr, mem_word(exp_q[0]));
        check("id_pc_plus4", m.id_pc_plus4, exp_q[0] + 32'd4);
      end
      if (exp_q.size() == 0) begin
        check("empty_id_pc",    m.id_pc, 32'd0);
        check("empty_id_instr", m.id_instr, 32'd0);
      end
      check("occupancy", 32'(m.dbg_occupancy), 32'(exp_q.size()));
    end

    // ---- model update for the coming edge ----
    req_fire = m.imem_req_valid && m.imem_req_ready;
    id_fire  = m.id_valid && m.id_ready;
    if (do_rst) begin
      mem_q.delete();
      exp_q.delete();
      filled   = 0;
      exp_addr = RESET_PC;
      epoch++;
      boot = 1'b1;
    end else begin
      boot = 1'b0;
      if (rsp_now) begin
        e = mem_q.pop_front();
        if (!do_redir && e.epoch == epoch) filled++;
      end
      if (do_redir) begin
        exp_q.delete();
        filled   = 0;
        epoch++;
        exp_addr = {tgt[31:2], 2'b00};
      end else begin
        if (id_fire && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          filled--;
        end
        if (req_fire) begin
          mem_q.push_back('{addr: m.imem_req_addr, epoch: epoch,
                            due: cyc + 1 + int'($urandom_range(lat_max))});
          exp_q.push_back(exp_addr);
          exp_addr = exp_addr + 32'd4;
        end
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
  endtask

  task automatic speed(input int rq, input int id, input int rs, input int lat);
    req_rdy_pct = rq;
    id_rdy_pct  = id;
    rsp_pct     = rs;
    lat_max     = lat;
  endtask

  // ---- directed sequence --------------------------------------------------
  initial begin
    reset            = 1'b1;
    m.imem_req_ready = 1'b0;
    m.imem_rsp_valid = 1'b0;
    m.imem_rsp_data  = '0;
    m.redirect_valid = 1'b0;
    m.redirect_pc    = '0;
    m.id_ready       = 1'b0;
    exp_addr = RESET_PC;
    filled = 0; epoch = 0; boot = 1'b0; cyc = 0; checks = 0; errors = 0;

    // streaming from reset, one-cycle memory, decode always ready
    speed(100, 100, 100, 0);
    do_reset();
    run(20);

    // decode stalls: issue must stop at DEPTH outstanding, then resume
    speed(100, 0, 100, 0);
    run(8);
    speed(100, 100, 100, 0);
    run(10);

    // two requests pending, redirect to an unaligned target
    do_reset();
    speed(100, 100, 0, 0);
    run(3);
    speed(100, 100, 100, 0);
    step(1'b0, 1'b1, 32'h0000_0103);
    run(12);

    // memory stalls the request at pc 0x8 for three cycles
    do_reset();
    speed(100, 100, 100, 0);
    run(3);
    speed(0, 100, 100, 0);
    run(3);
    speed(100, 100, 100, 0);
    run(8);

    // redirect in a busy cycle, then back-to-back redirects
    run(5);
    step(1'b0, 1'b1, 32'h0000_0200);
    run(4);
    step(1'b0, 1'b1, 32'h0000_0300);
    step(1'b0, 1'b1, 32'h0000_0404);
    run(10);

    // PC wraps past the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFF4);
    run(10);

    // randomized traffic with occasional redirects
    speed(70, 70, 70, 3);
    for (int i = 0; i < 600; i++)
      step(1'b0, ($urandom_range(24) == 0), $urandom);

    // reset with the queue full
    speed(100, 0, 100, 0);
    run(6);
    do_reset();
    speed(100, 100, 100, 0);
    run(6);

    // drain: stop new requests and make sure every fetch reached decode
    speed(0, 100, 100, 1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) run(1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
